// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolution stage.
//   DATA_W  : operand / pc width
//   br_op_e : branch operation encoding
//   state_e : resolution FSM states
package br_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b010,
    BR_BGE  = 3'b011,
    BR_BLTU = 3'b100,
    BR_BGEU = 3'b101,
    BR_JAL  = 3'b110,
    BR_ILL  = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_REDIRECT,
    ST_FLUSH
  } state_e;

  // Signed compares reuse the unsigned comparator by flipping the sign bit.
  function automatic logic is_signed_op(input br_op_e op);
    return (op == BR_BLT) || (op == BR_BGE);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bundle of all branch_resolve data/handshake signals.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; a source holds valid and its payload stable until
// that edge, and ready never depends combinationally on valid.
//   in_*       : decoded branch request (upstream -> stage)
//   redirect_* : fetch redirect request (stage -> fetch)
//   done_*     : one-cycle result pulse with compare flags
//   cnt_*      : statistics counters and their clear
//   state_dbg  : current FSM state for observation
// Modports: slave = the stage, master = its environment.
interface branch_resolve_if import br_pkg::*; #(
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        br_op;
  logic [DATA_W-1:0] rs1_reg;
  logic [DATA_W-1:0] rs2_reg;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] imm;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [DATA_W-1:0] redirect_pc;
  logic              flush;
  logic              done_valid;
  logic              done_taken;
  logic              done_eq;
  logic              done_gt;
  logic              done_lt;
  logic              illegal_op;
  logic              cnt_clr;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  taken_cnt;
  state_e            state_dbg;

  modport slave (
    input  in_valid, br_op, rs1_reg, rs2_reg, pc, imm, redirect_ready, cnt_clr,
    output in_ready, redirect_valid, redirect_pc, flush, done_valid, done_taken,
           done_eq, done_gt, done_lt, illegal_op, br_cnt, taken_cnt, state_dbg
  );

  modport master (
    output in_valid, br_op, rs1_reg, rs2_reg, pc, imm, redirect_ready, cnt_clr,
    input  in_ready, redirect_valid, redirect_pc, flush, done_valid, done_taken,
           done_eq, done_gt, done_lt, illegal_op, br_cnt, taken_cnt, state_dbg
  );
endinterface

// File: rtl/branch_resolve_comp.sv
// comp: 16-bit unsigned magnitude comparator, purely combinational.
//   a_i, b_i : operands
//   eq_o     : a == b
//   gt_o     : a >  b
//   lt_o     : a <  b
module comp import br_pkg::*; (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              eq_o,
  output logic              gt_o,
  output logic              lt_o
);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves one branch at a time.
// Accepts a branch in IDLE, compares its registered operands in EVAL and
// pulses the result, holds a fetch redirect in REDIRECT when taken, then
// squashes younger instructions for FLUSH_CYCLES cycles in FLUSH.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolve_if.slave (request, redirect, result, counters)
module branch_resolve import br_pkg::*; #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD =
    FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state_q, state_d;
  br_op_e            op_q, op_d;
  logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rpc_q, rpc_d;
  logic              flush_q, flush_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              dv_q, dv_d, dtk_q, dtk_d, deq_q, deq_d;
  logic              dgt_q, dgt_d, dlt_q, dlt_d, ill_q, ill_d;
  logic [CNT_W-1:0]  brc_q, brc_d, tkc_q, tkc_d;

  logic [DATA_W-1:0] cmp_a, cmp_b, target;
  logic              eq, gt, lt, taken;

  // Flipping bit 15 maps two's-complement order onto unsigned order.
  assign cmp_a  = is_signed_op(op_q) ? (rs1_q ^ SIGN_BIT) : rs1_q;
  assign cmp_b  = is_signed_op(op_q) ? (rs2_q ^ SIGN_BIT) : rs2_q;
  assign target = pc_q + imm_q;  // carry discarded: wraps mod 2^16

  comp u_comp (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .eq_o (eq),
    .gt_o (gt),
    .lt_o (lt)
  );

  always_comb begin
    taken = 1'b0;
    case (op_q)
      BR_BEQ:           taken = eq;
      BR_BNE:           taken = !eq;
      BR_BLT, BR_BLTU:  taken = lt;
      BR_BGE, BR_BGEU:  taken = gt | eq;
      BR_JAL:           taken = 1'b1;
      default:          taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    flush_d = flush_q;
    fcnt_d  = fcnt_q;
    dv_d    = 1'b0;
    dtk_d   = 1'b0;
    deq_d   = 1'b0;
    dgt_d   = 1'b0;
    dlt_d   = 1'b0;
    ill_d   = 1'b0;
    brc_d   = brc_q;
    tkc_d   = tkc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = br_op_e'(bus.br_op);
          rs1_d   = bus.rs1_reg;
          rs2_d   = bus.rs2_reg;
          pc_d    = bus.pc;
          imm_d   = bus.imm;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        dv_d  = 1'b1;
        dtk_d = taken;
        deq_d = eq;
        dgt_d = gt;
        dlt_d = lt;
        ill_d = (op_q == BR_ILL);
        if (brc_q != CNT_MAX) brc_d = brc_q + CNT_W'(1);
        if (taken && (tkc_q != CNT_MAX)) tkc_d = tkc_q + CNT_W'(1);
        if (taken) begin
          rv_d    = 1'b1;
          rpc_d   = target;
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          rv_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            flush_d = 1'b1;
            fcnt_d  = FC_LOAD;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear has priority over any increment made this cycle.
    if (bus.cnt_clr) begin
      brc_d = '0;
      tkc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= BR_BEQ;
      rs1_q   <= '0;
      rs2_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      fcnt_q  <= '0;
      dv_q    <= 1'b0;
      dtk_q   <= 1'b0;
      deq_q   <= 1'b0;
      dgt_q   <= 1'b0;
      dlt_q   <= 1'b0;
      ill_q   <= 1'b0;
      brc_q   <= '0;
      tkc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      dv_q    <= dv_d;
      dtk_q   <= dtk_d;
      deq_q   <= deq_d;
      dgt_q   <= dgt_d;
      dlt_q   <= dlt_d;
      ill_q   <= ill_d;
      brc_q   <= brc_d;
      tkc_q   <= tkc_d;
    end
  end

  assign bus.in_ready       = (state_q == ST_IDLE);
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush          = flush_q;
  assign bus.done_valid     = dv_q;
  assign bus.done_taken     = dtk_q;
  assign bus.done_eq        = deq_q;
  assign bus.done_gt        = dgt_q;
  assign bus.done_lt        = dlt_q;
  assign bus.illegal_op     = ill_q;
  assign bus.br_cnt         = brc_q;
  assign bus.taken_cnt      = tkc_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: three instances (default, no flush, 2-bit
// counters) driven by directed vectors; results checked by a scoreboard.
module tb_branch_resolve;
  import br_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.CNT_W(16)) ifa ();
  branch_resolve_if #(.CNT_W(16)) ifb ();
  branch_resolve_if #(.CNT_W(2))  ifc ();

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  branch_resolve #(.FLUSH_CYCLES(0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(2))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // entry = {taken, eq, gt, lt, illegal, target}
  logic [20:0] exp_a_q[$];
  logic [20:0] exp_b_q[$];
  logic [20:0] exp_c_q[$];
  logic flush_seen_b = 1'b0;

  function automatic logic [20:0] mk(input logic tk, input logic e, input logic g,
                                     input logic l, input logic il, input logic [15:0] t);
    return {tk, e, g, l, il, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input string tag, input logic [20:0] e, input logic [4:0] flags,
                     input logic rv, input logic [15:0] rpc);
    chk({tag, "_flags"}, 32'(flags), 32'(e[20:16]));
    if (e[20]) chk({tag, "_redirect"}, 32'({rv, rpc}), 32'({1'b1, e[15:0]}));
    else       chk({tag, "_no_redirect"}, 32'(rv), 32'd0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    logic [20:0] e;
    if (!rst && ifa.done_valid) begin
      if (exp_a_q.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = exp_a_q.pop_front();
        mon("a_done", e, {ifa.done_taken, ifa.done_eq, ifa.done_gt, ifa.done_lt, ifa.illegal_op},
            ifa.redirect_valid, ifa.redirect_pc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [20:0] e;
    if (ifb.flush) flush_seen_b = 1'b1;
    if (!rst && ifb.done_valid) begin
      if (exp_b_q.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = exp_b_q.pop_front();
        mon("b_done", e, {ifb.done_taken, ifb.done_eq, ifb.done_gt, ifb.done_lt, ifb.illegal_op},
            ifb.redirect_valid, ifb.redirect_pc);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [20:0] e;
    if (!rst && ifc.done_valid) begin
      if (exp_c_q.size() == 0) chk("c_unexpected_done", 1, 0);
      else begin
        e = exp_c_q.pop_front();
        mon("c_done", e, {ifc.done_taken, ifc.done_eq, ifc.done_gt, ifc.done_lt, ifc.illegal_op},
            ifc.redirect_valid, ifc.redirect_pc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return ifa.in_ready;
      1:       return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] p, input logic [15:0] i);
    case (d)
      0: begin ifa.in_valid = v; ifa.br_op = op; ifa.rs1_reg = a; ifa.rs2_reg = b; ifa.pc = p; ifa.imm = i; end
      1: begin ifb.in_valid = v; ifb.br_op = op; ifb.rs1_reg = a; ifb.rs2_reg = b; ifb.pc = p; ifb.imm = i; end
      default: begin ifc.in_valid = v; ifc.br_op = op; ifc.rs1_reg = a; ifc.rs2_reg = b; ifc.pc = p; ifc.imm = i; end
    endcase
  endtask

  task automatic set_rr(input int d, input logic v);
    case (d)
      0:       ifa.redirect_ready = v;
      1:       ifb.redirect_ready = v;
      default: ifc.redirect_ready = v;
    endcase
  endtask

  task automatic push(input int d, input logic [20:0] e);
    case (d)
      0:       exp_a_q.push_back(e);
      1:       exp_b_q.push_back(e);
      default: exp_c_q.push_back(e);
    endcase
  endtask

  // Waits for in_ready, presents one request for exactly the accept edge.
  task automatic send(input int d, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] p, input logic [15:0] i,
                      input logic [20:0] e);
    int n = 0;
    while (!rdy(d) && n < 20) begin tick(); n++; end
    if (!rdy(d)) chk("send_ready_timeout", 0, 1);
    set_in(d, 1'b1, op, a, b, p, i);
    push(d, e);
    tick();
    set_in(d, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic accept_redirect(input int d);
    int n = 0;
    set_rr(d, 1'b1);
    tick();
    set_rr(d, 1'b0);
    while (!rdy(d) && n < 10) begin tick(); n++; end
    if (!rdy(d)) chk("redirect_idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int fc;
    rst = 1'b1;
    ifa.cnt_clr = 1'b0; ifb.cnt_clr = 1'b0; ifc.cnt_clr = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);
      set_rr(d, 1'b0);
    end
    tick(); tick();
    chk("rst_in_ready",   32'(ifa.in_ready), 1);
    chk("rst_state",      32'(ifa.state_dbg), 32'(ST_IDLE));
    chk("rst_redirect",   32'({ifa.redirect_valid, ifa.redirect_pc}), 0);
    chk("rst_flush",      32'(ifa.flush), 0);
    chk("rst_done",       32'({ifa.done_valid, ifa.done_taken, ifa.illegal_op}), 0);
    chk("rst_counters",   32'({ifa.br_cnt, ifa.taken_cnt}), 0);
    rst = 1'b0;
    tick();

    // BEQ taken with a stalled redirect and a two-cycle flush
    send(0, BR_BEQ, 16'h1234, 16'h1234, 16'h0100, 16'h0010, mk(1, 1, 0, 0, 0, 16'h0110));
    chk("beq_in_eval", 32'(ifa.state_dbg), 32'(ST_EVAL));
    tick();
    chk("beq_latency_done", 32'(ifa.done_valid), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("beq_redirect_hold", 32'({ifa.redirect_valid, ifa.redirect_pc}), 32'({1'b1, 16'h0110}));
    end
    set_rr(0, 1'b1);
    tick();
    set_rr(0, 1'b0);
    chk("beq_redirect_drop", 32'(ifa.redirect_valid), 0);
    fc = 0;
    while (ifa.flush && fc < 10) begin fc++; tick(); end
    chk("beq_flush_len", 32'(fc), 2);
    chk("beq_idle_after_flush", 32'(ifa.in_ready), 1);

    // BLT signed: -1 < 1
    send(0, BR_BLT, 16'hFFFF, 16'h0001, 16'h0200, 16'hFFF0, mk(1, 0, 0, 1, 0, 16'h01F0));
    tick();
    accept_redirect(0);

    // BLTU same operands: not taken, then a back-to-back request in the done cycle
    send(0, BR_BLTU, 16'hFFFF, 16'h0001, 16'h0300, 16'h0004, mk(0, 0, 1, 0, 0, 16'h0304));
    tick();
    chk("bltu_done_ready", 32'({ifa.done_valid, ifa.in_ready}), 32'(2'b11));
    chk("bltu_no_flush", 32'({ifa.flush, ifa.redirect_valid}), 0);
    set_in(0, 1'b1, BR_BNE, 16'h0005, 16'h0006, 16'h0400, 16'h0008);
    push(0, mk(1, 0, 0, 1, 0, 16'h0408));
    tick();
    set_in(0, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("b2b_accepted", 32'(ifa.state_dbg), 32'(ST_EVAL));
    chk("bltu_no_flush_later", 32'(ifa.flush), 0);
    tick();
    accept_redirect(0);

    // BGE signed: -32768 >= 32767 is false; BGEU same operands is true
    send(0, BR_BGE, 16'h8000, 16'h7FFF, 16'h0500, 16'h0010, mk(0, 0, 0, 1, 0, 16'h0510));
    tick();
    send(0, BR_BGEU, 16'h8000, 16'h7FFF, 16'h0600, 16'h0010, mk(1, 0, 1, 0, 0, 16'h0610));
    tick();
    accept_redirect(0);
    chk("cnt_before_ill", 32'({ifa.br_cnt, ifa.taken_cnt}), 32'({16'd6, 16'd4}));

    // illegal op counts as a resolution but is never taken
    send(0, BR_ILL, 16'h0003, 16'h0003, 16'h0700, 16'h0001, mk(0, 1, 0, 0, 1, 16'h0701));
    tick();
    chk("cnt_after_ill", 32'({ifa.br_cnt, ifa.taken_cnt}), 32'({16'd7, 16'd4}));

    // reset while a redirect is pending discards it
    send(0, BR_JAL, 16'h0000, 16'h0000, 16'h1000, 16'h0004, mk(1, 1, 0, 0, 0, 16'h1004));
    tick();
    tick();
    chk("pre_rst_redirect", 32'(ifa.state_dbg), 32'(ST_REDIRECT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outputs", 32'({ifa.redirect_valid, ifa.flush, ifa.in_ready}), 32'(3'b001));
    chk("mid_rst_counters", 32'({ifa.br_cnt, ifa.taken_cnt}), 0);
    set_rr(0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_quiet", 32'({ifa.flush, ifa.redirect_valid}), 0);
    end
    set_rr(0, 1'b0);

    // FLUSH_CYCLES=0: JAL with wrap-around target, straight back to IDLE
    send(1, BR_JAL, 16'h0000, 16'h0000, 16'hFFF0, 16'h0020, mk(1, 1, 0, 0, 0, 16'h0010));
    tick();
    set_rr(1, 1'b1);
    tick();
    set_rr(1, 1'b0);
    chk("b_idle_after_accept", 32'({ifb.redirect_valid, ifb.flush, ifb.in_ready}), 32'(3'b001));
    tick(); tick();

    // CNT_W=2: counters saturate at 3, clear wins over an increment
    for (int k = 0; k < 5; k++) begin
      send(2, BR_JAL, 16'h0000, 16'h0000, 16'(k * 16'h40), 16'h0008,
           mk(1, 1, 0, 0, 0, 16'(k * 16'h40 + 16'h8)));
      tick();
      accept_redirect(2);
    end
    chk("c_saturated", 32'({ifc.br_cnt, ifc.taken_cnt}), 32'(4'b1111));
    send(2, BR_JAL, 16'h0000, 16'h0000, 16'h0500, 16'h0008, mk(1, 1, 0, 0, 0, 16'h0508));
    ifc.cnt_clr = 1'b1;
    tick();
    ifc.cnt_clr = 1'b0;
    chk("c_clear_done", 32'(ifc.done_valid), 1);
    chk("c_clear_wins", 32'({ifc.br_cnt, ifc.taken_cnt}), 0);
    accept_redirect(2);

    repeat (3) tick();
    chk("b_never_flushed", 32'(flush_seen_b), 0);
    chk("a_queue_drained", 32'(exp_a_q.size()), 0);
    chk("b_queue_drained", 32'(exp_b_q.size()), 0);
    chk("c_queue_drained", 32'(exp_c_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
